// File: rtl/tx_emac_pkg.sv
// Shared types for the 10G MAC transmit ingress port: stored packet word,
// framing FSM state and the "all bytes valid" mod encoding.
package tx_emac_pkg;

  typedef struct packed {
    logic [63:0] data;
    logic        sop;
    logic        eop;
    logic [2:0]  mod;
  } pkt_word_t;

  typedef enum logic {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } tx_state_e;

  localparam logic [2:0] MOD_FULL = 3'd0;

endpackage

// File: rtl/tx_emac_port_if.sv
// Bundle of host-side packet signals, MAC-side FIFO read signals and status
// outputs of tx_emac_port; master = host/MAC environment, slave = the port.
interface tx_emac_port_if;

  logic [63:0] pkt_tx_data;
  logic        pkt_tx_sop;
  logic        pkt_tx_eop;
  logic [2:0]  pkt_tx_mod;
  logic        pkt_tx_val;
  logic        pkt_tx_full;

  logic        txf_ren;
  logic [63:0] txf_data;
  logic        txf_sop;
  logic        txf_eop;
  logic [2:0]  txf_mod;
  logic        txf_val;
  logic        txf_empty;

  logic        err_no_sop;
  logic        err_sop_in_pkt;
  logic        err_overflow;
  logic [31:0] tx_pkt_cnt;

  modport master (
    output pkt_tx_data, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod, pkt_tx_val, txf_ren,
    input  pkt_tx_full, txf_data, txf_sop, txf_eop, txf_mod, txf_val, txf_empty,
    input  err_no_sop, err_sop_in_pkt, err_overflow, tx_pkt_cnt
  );

  modport slave (
    input  pkt_tx_data, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod, pkt_tx_val, txf_ren,
    output pkt_tx_full, txf_data, txf_sop, txf_eop, txf_mod, txf_val, txf_empty,
    output err_no_sop, err_sop_in_pkt, err_overflow, tx_pkt_cnt
  );

endinterface

// File: rtl/tx_emac_sync_fifo.sv
// Single-clock FIFO with registered read port (1-cycle pop latency) and
// both current and next-cycle occupancy outputs.
module tx_emac_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 69
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_val,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH):0]   count_next
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_val_q, rd_val_d;
  logic             do_wr, do_rd;

  assign do_wr = wr_en && (count_q != DEPTH_C);
  assign do_rd = rd_en && (count_q != '0);

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    rd_data_d = rd_data_q;
    rd_val_d  = do_rd;
    if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_rd) begin
      rd_ptr_d  = rd_ptr_q + 1'b1;
      rd_data_d = mem_q[rd_ptr_q];
    end
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage is not reset: stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
      rd_val_q  <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rd_data_q <= rd_data_d;
      rd_val_q  <= rd_val_d;
    end
  end

  assign rd_data    = rd_data_q;
  assign rd_val     = rd_val_q;
  assign count      = count_q;
  assign count_next = count_d;

endmodule

// File: rtl/tx_emac_port.sv
// 10G MAC transmit ingress port: sop/eop framing check, word FIFO, near-full
// back-pressure. Optional accepted-packet counter enabled by TX_PKT_CNT_EN.
module tx_emac_port
  import tx_emac_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int FULL_MARGIN = 4
) (
  input  logic           clk_156m25,
  input  logic           reset_156m25_n,
  tx_emac_port_if.slave  port_if
);

  localparam int          AW         = $clog2(DEPTH);
  localparam int          FULL_THR_I = DEPTH - FULL_MARGIN;
  localparam logic [AW:0] DEPTH_C    = DEPTH[AW:0];
  localparam logic [AW:0] FULL_THR   = FULL_THR_I[AW:0];

  tx_state_e   state_q, state_d;
  logic        err_no_sop_q, err_no_sop_d;
  logic        err_sop_q, err_sop_d;
  logic        err_ovf_q, err_ovf_d;
  logic        full_q, full_d;
  logic        empty_q, empty_d;
  logic        write_req, write_ok;
  pkt_word_t   wr_word, rd_word;
  logic        rd_val;
  logic [AW:0] occ, occ_next;

  always_comb begin
    state_d      = state_q;
    write_req    = 1'b0;
    err_no_sop_d = 1'b0;
    err_sop_d    = 1'b0;
    if (port_if.pkt_tx_val) begin
      unique case (state_q)
        IDLE: begin
          if (port_if.pkt_tx_sop) begin
            write_req = 1'b1;
            state_d   = port_if.pkt_tx_eop ? IDLE : IN_PKT;
          end else begin
            err_no_sop_d = 1'b1;
          end
        end
        IN_PKT: begin
          write_req = 1'b1;
          err_sop_d = port_if.pkt_tx_sop;
          state_d   = port_if.pkt_tx_eop ? IDLE : IN_PKT;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Acceptance looks at current occupancy only; a same-cycle pop does not free a slot.
  assign write_ok  = write_req && (occ < DEPTH_C);
  assign err_ovf_d = write_req && !write_ok;

  always_comb begin
    wr_word.data = port_if.pkt_tx_data;
    wr_word.sop  = port_if.pkt_tx_sop;
    wr_word.eop  = port_if.pkt_tx_eop;
    wr_word.mod  = port_if.pkt_tx_eop ? port_if.pkt_tx_mod : MOD_FULL;
  end

  tx_emac_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(pkt_word_t))
  ) u_fifo (
    .clk        (clk_156m25),
    .rst_n      (reset_156m25_n),
    .wr_en      (write_ok),
    .wr_data    (wr_word),
    .rd_en      (port_if.txf_ren),
    .rd_data    (rd_word),
    .rd_val     (rd_val),
    .count      (occ),
    .count_next (occ_next)
  );

  assign full_d  = (occ_next >= FULL_THR);
  assign empty_d = (occ_next == '0);

  always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
    if (!reset_156m25_n) begin
      state_q      <= IDLE;
      err_no_sop_q <= 1'b0;
      err_sop_q    <= 1'b0;
      err_ovf_q    <= 1'b0;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      err_no_sop_q <= err_no_sop_d;
      err_sop_q    <= err_sop_d;
      err_ovf_q    <= err_ovf_d;
      full_q       <= full_d;
      empty_q      <= empty_d;
    end
  end

`ifdef TX_PKT_CNT_EN
  logic [31:0] pkt_cnt_q, pkt_cnt_d;

  assign pkt_cnt_d = pkt_cnt_q + 32'(write_ok && port_if.pkt_tx_eop);

  always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
    if (!reset_156m25_n) pkt_cnt_q <= '0;
    else                 pkt_cnt_q <= pkt_cnt_d;
  end

  assign port_if.tx_pkt_cnt = pkt_cnt_q;
`else
  assign port_if.tx_pkt_cnt = '0;
`endif

  assign port_if.pkt_tx_full    = full_q;
  assign port_if.txf_empty      = empty_q;
  assign port_if.txf_data       = rd_word.data;
  assign port_if.txf_sop        = rd_word.sop;
  assign port_if.txf_eop        = rd_word.eop;
  assign port_if.txf_mod        = rd_word.mod;
  assign port_if.txf_val        = rd_val;
  assign port_if.err_no_sop     = err_no_sop_q;
  assign port_if.err_sop_in_pkt = err_sop_q;
  assign port_if.err_overflow   = err_ovf_q;

endmodule

// File: tb/tb_tx_emac_port.sv
// Directed self-checking bench for tx_emac_port (DEPTH=16, FULL_MARGIN=4);
// counter expectations follow TX_PKT_CNT_EN.
module tb_tx_emac_port;

  logic clk_156m25;
  logic reset_156m25_n;
  int   checks;
  int   errors;
  logic [31:0] exp_cnt;

  tx_emac_port_if port_if ();

  tx_emac_port #(
    .DEPTH       (16),
    .FULL_MARGIN (4)
  ) dut (
    .clk_156m25     (clk_156m25),
    .reset_156m25_n (reset_156m25_n),
    .port_if        (port_if)
  );

  initial clk_156m25 = 1'b0;
  always #5 clk_156m25 = ~clk_156m25;

  function automatic logic [31:0] cnt_expected();
`ifdef TX_PKT_CNT_EN
    return exp_cnt;
`else
    return 32'd0;
`endif
  endfunction

  // Drivers start and end on a falling edge, so outputs are sampled mid-cycle.
  task automatic send(input logic [63:0] d, input logic s, input logic e, input logic [2:0] m);
    port_if.pkt_tx_data = d;
    port_if.pkt_tx_sop  = s;
    port_if.pkt_tx_eop  = e;
    port_if.pkt_tx_mod  = m;
    port_if.pkt_tx_val  = 1'b1;
    @(negedge clk_156m25);
    port_if.pkt_tx_val  = 1'b0;
    port_if.pkt_tx_sop  = 1'b0;
    port_if.pkt_tx_eop  = 1'b0;
  endtask

  task automatic pop();
    port_if.txf_ren = 1'b1;
    @(negedge clk_156m25);
    port_if.txf_ren = 1'b0;
  endtask

  task automatic test_reset();
    reset_156m25_n      = 1'b0;
    port_if.pkt_tx_val  = 1'b0;
    port_if.pkt_tx_sop  = 1'b0;
    port_if.pkt_tx_eop  = 1'b0;
    port_if.pkt_tx_mod  = 3'd0;
    port_if.pkt_tx_data = 64'd0;
    port_if.txf_ren     = 1'b0;
    exp_cnt             = 32'd0;
    repeat (3) @(negedge clk_156m25);
    reset_156m25_n = 1'b1;
    @(negedge clk_156m25);
    checks++;
    if ({port_if.txf_empty, port_if.pkt_tx_full, port_if.txf_val} !== 3'b100) begin
      errors++;
      $display("[TB] FAIL reset_flags: got empty/full/val=%b expected 100",
               {port_if.txf_empty, port_if.pkt_tx_full, port_if.txf_val});
    end
    checks++;
    if ({port_if.txf_sop, port_if.txf_eop, port_if.txf_mod, port_if.txf_data} !== 69'd0) begin
      errors++;
      $display("[TB] FAIL reset_txf: got %h expected 0",
               {port_if.txf_sop, port_if.txf_eop, port_if.txf_mod, port_if.txf_data});
    end
    checks++;
    if ({port_if.err_no_sop, port_if.err_sop_in_pkt, port_if.err_overflow} !== 3'b000
        || port_if.tx_pkt_cnt !== 32'd0) begin
      errors++;
      $display("[TB] FAIL reset_err_cnt: got errs=%b cnt=%0d expected 000 / 0",
               {port_if.err_no_sop, port_if.err_sop_in_pkt, port_if.err_overflow},
               port_if.tx_pkt_cnt);
    end
  endtask

  task automatic test_three_word();
    logic [63:0] d [3];
    logic [69:0] exp_w [3];
    d[0] = 64'h1111_2222_3333_0000;
    d[1] = 64'h1111_2222_3333_0001;
    d[2] = 64'h1111_2222_3333_0002;
    exp_w[0] = {1'b1, 1'b1, 1'b0, 3'd0, d[0]};
    exp_w[1] = {1'b1, 1'b0, 1'b0, 3'd0, d[1]};
    exp_w[2] = {1'b1, 1'b0, 1'b1, 3'd5, d[2]};
    send(d[0], 1'b1, 1'b0, 3'd3);
    checks++;
    if (port_if.txf_empty !== 1'b0) begin
      errors++;
      $display("[TB] FAIL three_word_empty: got %b expected 0", port_if.txf_empty);
    end
    send(d[1], 1'b0, 1'b0, 3'd7);
    send(d[2], 1'b0, 1'b1, 3'd5);
    exp_cnt = exp_cnt + 1;
    for (int i = 0; i < 3; i++) begin
      pop();
      checks++;
      if ({port_if.txf_val, port_if.txf_sop, port_if.txf_eop, port_if.txf_mod, port_if.txf_data}
          !== exp_w[i]) begin
        errors++;
        $display("[TB] FAIL three_word_pop%0d: got %h expected %h", i,
                 {port_if.txf_val, port_if.txf_sop, port_if.txf_eop, port_if.txf_mod,
                  port_if.txf_data}, exp_w[i]);
      end
    end
    checks++;
    if (port_if.txf_empty !== 1'b1 || port_if.tx_pkt_cnt !== cnt_expected()) begin
      errors++;
      $display("[TB] FAIL three_word_end: got empty=%b cnt=%0d expected 1 / %0d",
               port_if.txf_empty, port_if.tx_pkt_cnt, cnt_expected());
    end
  endtask

  task automatic test_no_sop();
    send(64'hDEAD_0000_0000_0001, 1'b0, 1'b1, 3'd2);
    checks++;
    if ({port_if.err_no_sop, port_if.txf_empty} !== 2'b11) begin
      errors++;
      $display("[TB] FAIL no_sop_pulse: got err/empty=%b expected 11",
               {port_if.err_no_sop, port_if.txf_empty});
    end
    @(negedge clk_156m25);
    checks++;
    if ({port_if.err_no_sop, port_if.txf_empty} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL no_sop_clear: got err/empty=%b expected 01",
               {port_if.err_no_sop, port_if.txf_empty});
    end
  endtask

  task automatic test_sop_in_pkt();
    logic [69:0] exp_w [3];
    exp_w[0] = {1'b1, 1'b1, 1'b0, 3'd0, 64'h5500_0000_0000_0000};
    exp_w[1] = {1'b1, 1'b1, 1'b0, 3'd0, 64'h5500_0000_0000_0001};
    exp_w[2] = {1'b1, 1'b0, 1'b1, 3'd4, 64'h5500_0000_0000_0002};
    send(64'h5500_0000_0000_0000, 1'b1, 1'b0, 3'd6);
    checks++;
    if (port_if.err_sop_in_pkt !== 1'b0) begin
      errors++;
      $display("[TB] FAIL sop_in_pkt_first: got %b expected 0", port_if.err_sop_in_pkt);
    end
    send(64'h5500_0000_0000_0001, 1'b1, 1'b0, 3'd2);
    checks++;
    if (port_if.err_sop_in_pkt !== 1'b1) begin
      errors++;
      $display("[TB] FAIL sop_in_pkt_pulse: got %b expected 1", port_if.err_sop_in_pkt);
    end
    send(64'h5500_0000_0000_0002, 1'b0, 1'b1, 3'd4);
    exp_cnt = exp_cnt + 1;
    checks++;
    if (port_if.err_sop_in_pkt !== 1'b0) begin
      errors++;
      $display("[TB] FAIL sop_in_pkt_clear: got %b expected 0", port_if.err_sop_in_pkt);
    end
    for (int i = 0; i < 3; i++) begin
      pop();
      checks++;
      if ({port_if.txf_val, port_if.txf_sop, port_if.txf_eop, port_if.txf_mod, port_if.txf_data}
          !== exp_w[i]) begin
        errors++;
        $display("[TB] FAIL sop_in_pkt_pop%0d: got %h expected %h", i,
                 {port_if.txf_val, port_if.txf_sop, port_if.txf_eop, port_if.txf_mod,
                  port_if.txf_data}, exp_w[i]);
      end
    end
  endtask

  task automatic test_single_word();
    send(64'h0123_4567_89AB_CDEF, 1'b1, 1'b1, 3'd0);
    exp_cnt = exp_cnt + 1;
    send(64'h0123_4567_89AB_CDF0, 1'b1, 1'b1, 3'd1);
    exp_cnt = exp_cnt + 1;
    checks++;
    if (port_if.err_sop_in_pkt !== 1'b0 || port_if.tx_pkt_cnt !== cnt_expected()) begin
      errors++;
      $display("[TB] FAIL single_word: got sop_err=%b cnt=%0d expected 0 / %0d",
               port_if.err_sop_in_pkt, port_if.tx_pkt_cnt, cnt_expected());
    end
    pop();
    pop();
    checks++;
    if ({port_if.txf_val, port_if.txf_sop, port_if.txf_eop, port_if.txf_mod, port_if.txf_data}
        !== {1'b1, 1'b1, 1'b1, 3'd1, 64'h0123_4567_89AB_CDF0}) begin
      errors++;
      $display("[TB] FAIL single_word_pop: got %h expected %h",
               {port_if.txf_val, port_if.txf_sop, port_if.txf_eop, port_if.txf_mod,
                port_if.txf_data}, {1'b1, 1'b1, 1'b1, 3'd1, 64'h0123_4567_89AB_CDF0});
    end
  endtask

  task automatic test_back_to_back();
    send(64'hB2B0_0000_0000_0000, 1'b1, 1'b0, 3'd0);
    port_if.pkt_tx_data = 64'hB2B0_0000_0000_0001;
    port_if.pkt_tx_sop  = 1'b0;
    port_if.pkt_tx_eop  = 1'b1;
    port_if.pkt_tx_mod  = 3'd2;
    port_if.pkt_tx_val  = 1'b1;
    port_if.txf_ren     = 1'b1;
    @(negedge clk_156m25);
    port_if.pkt_tx_val  = 1'b0;
    port_if.txf_ren     = 1'b0;
    exp_cnt = exp_cnt + 1;
    checks++;
    if ({port_if.txf_val, port_if.txf_data, port_if.txf_empty}
        !== {1'b1, 64'hB2B0_0000_0000_0000, 1'b0}) begin
      errors++;
      $display("[TB] FAIL b2b_simul: got val=%b data=%h empty=%b expected 1 b2b0000000000000 0",
               port_if.txf_val, port_if.txf_data, port_if.txf_empty);
    end
    pop();
    checks++;
    if ({port_if.txf_val, port_if.txf_eop, port_if.txf_mod, port_if.txf_data, port_if.txf_empty}
        !== {1'b1, 1'b1, 3'd2, 64'hB2B0_0000_0000_0001, 1'b1}) begin
      errors++;
      $display("[TB] FAIL b2b_second: got val=%b eop=%b mod=%0d data=%h empty=%b",
               port_if.txf_val, port_if.txf_eop, port_if.txf_mod, port_if.txf_data,
               port_if.txf_empty);
    end
    pop();
    checks++;
    if ({port_if.txf_val, port_if.txf_data} !== {1'b0, 64'hB2B0_0000_0000_0001}) begin
      errors++;
      $display("[TB] FAIL pop_when_empty: got val=%b data=%h expected 0 b2b0000000000001",
               port_if.txf_val, port_if.txf_data);
    end
  endtask

  task automatic test_full();
    for (int i = 0; i < 12; i++) begin
      send(64'hF000_0000_0000_0000 | 64'(i), (i == 0), (i == 11), 3'd0);
      if (i == 10) begin
        checks++;
        if (port_if.pkt_tx_full !== 1'b0) begin
          errors++;
          $display("[TB] FAIL full_at_11: got %b expected 0", port_if.pkt_tx_full);
        end
      end
    end
    exp_cnt = exp_cnt + 1;
    checks++;
    if (port_if.pkt_tx_full !== 1'b1) begin
      errors++;
      $display("[TB] FAIL full_at_12: got %b expected 1", port_if.pkt_tx_full);
    end
    for (int i = 0; i < 12; i++) begin
      pop();
      if (i == 0) begin
        checks++;
        if (port_if.pkt_tx_full !== 1'b0) begin
          errors++;
          $display("[TB] FAIL full_after_pop: got %b expected 0", port_if.pkt_tx_full);
        end
      end
      checks++;
      if ({port_if.txf_val, port_if.txf_sop, port_if.txf_eop, port_if.txf_data}
          !== {1'b1, (i == 0), (i == 11), 64'hF000_0000_0000_0000 | 64'(i)}) begin
        errors++;
        $display("[TB] FAIL full_drain%0d: got val=%b sop=%b eop=%b data=%h", i,
                 port_if.txf_val, port_if.txf_sop, port_if.txf_eop, port_if.txf_data);
      end
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 17; i++) begin
      send(64'hA000_0000_0000_0000 | 64'(i), (i == 0), (i == 16), 3'd3);
      if (i == 15) begin
        checks++;
        if ({port_if.err_overflow, port_if.pkt_tx_full} !== 2'b01) begin
          errors++;
          $display("[TB] FAIL ovf_at_16: got err/full=%b expected 01",
                   {port_if.err_overflow, port_if.pkt_tx_full});
        end
      end
    end
    checks++;
    if (port_if.err_overflow !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ovf_pulse: got %b expected 1", port_if.err_overflow);
    end
    @(negedge clk_156m25);
    checks++;
    if (port_if.err_overflow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ovf_clear: got %b expected 0", port_if.err_overflow);
    end
    for (int i = 0; i < 16; i++) begin
      pop();
      checks++;
      if ({port_if.txf_val, port_if.txf_sop, port_if.txf_eop, port_if.txf_mod, port_if.txf_data}
          !== {1'b1, (i == 0), 1'b0, 3'd0, 64'hA000_0000_0000_0000 | 64'(i)}) begin
        errors++;
        $display("[TB] FAIL ovf_drain%0d: got val=%b sop=%b eop=%b mod=%0d data=%h", i,
                 port_if.txf_val, port_if.txf_sop, port_if.txf_eop, port_if.txf_mod,
                 port_if.txf_data);
      end
    end
    checks++;
    if (port_if.txf_empty !== 1'b1 || port_if.tx_pkt_cnt !== cnt_expected()) begin
      errors++;
      $display("[TB] FAIL ovf_end: got empty=%b cnt=%0d expected 1 / %0d",
               port_if.txf_empty, port_if.tx_pkt_cnt, cnt_expected());
    end
    send(64'hA000_0000_0000_00FF, 1'b0, 1'b0, 3'd0);
    checks++;
    if (port_if.err_no_sop !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ovf_fsm_idle: got err_no_sop=%b expected 1", port_if.err_no_sop);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) send(64'hC000_0000_0000_0000 | 64'(i), (i == 0), 1'b0, 3'd0);
    checks++;
    if (port_if.txf_empty !== 1'b0) begin
      errors++;
      $display("[TB] FAIL areset_pre: got empty=%b expected 0", port_if.txf_empty);
    end
    #2;
    reset_156m25_n = 1'b0;
    exp_cnt = 32'd0;
    #1;
    checks++;
    if ({port_if.txf_empty, port_if.pkt_tx_full, port_if.txf_val} !== 3'b100
        || port_if.tx_pkt_cnt !== 32'd0) begin
      errors++;
      $display("[TB] FAIL areset_now: got empty/full/val=%b cnt=%0d expected 100 / 0",
               {port_if.txf_empty, port_if.pkt_tx_full, port_if.txf_val}, port_if.tx_pkt_cnt);
    end
    @(negedge clk_156m25);
    reset_156m25_n = 1'b1;
    @(negedge clk_156m25);
    send(64'hC000_0000_0000_00FF, 1'b0, 1'b0, 3'd0);
    checks++;
    if ({port_if.err_no_sop, port_if.err_sop_in_pkt, port_if.txf_empty} !== 3'b101) begin
      errors++;
      $display("[TB] FAIL areset_idle: got no_sop/sop_in_pkt/empty=%b expected 101",
               {port_if.err_no_sop, port_if.err_sop_in_pkt, port_if.txf_empty});
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_three_word();
    test_no_sop();
    test_sop_in_pkt();
    test_single_word();
    test_back_to_back();
    test_full();
    test_overflow();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
